ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_pkg.sv | 15 +
 rtl/rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared sizing defaults and FSM state type for the RAM arbiter.
//   DEPTH   : default number of RAM words
//   WIDTH   : default RAM word width
//   state_t : arbiter FSM states (INIT clear sweep, RUN arbitration)
package ram_pkg;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIDTH = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant.
//   i_valid [1:0] : request valids
//   i_last        : requester granted most recently (0 or 1)
//   o_grant [1:0] : one-hot grant, all-zero when nothing is requested
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = '0;
      if (i_valid[0] && i_valid[1]) begin
         // contention goes to whoever did not win last time
         o_grant = i_last ? 2'b01 : 2'b10;
      end else if (i_valid[0]) begin
         o_grant = 2'b01;
      end else if (i_valid[1]) begin
         o_grant = 2'b10;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two command requesters onto one single-port RAM.
// After reset the RAM is cleared to zero by a write sweep, then commands are
// accepted one per cycle with round-robin priority. Reads are fully
// pipelined and return data to the issuing requester three cycles after
// acceptance.
//   clk, rst_n                : clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata  : requester N command (N = 0, 1)
//   reqN_ready                : command accepted when valid && ready
//   rspN_valid/rdata          : one-cycle read response to requester N
//   ram_en/we/addr/wdata      : registered RAM command
//   ram_rdata                 : RAM read data, one cycle after a read strobe
//   init_done                 : clear sweep finished
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH  = ram_pkg::DEPTH,
   parameter int unsigned DATA_W = ram_pkg::WIDTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              init_done
);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W:0]   r_init_cnt;
   logic              w_run;
   logic              w_issue_init;

   logic [1:0]        w_grant;
   logic              r_last;
   logic              w_acc;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_oob;

   logic              r_ram_en;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;

   logic              r_t1_vld, r_t1_id, r_t1_oob;
   logic              r_t2_vld, r_t2_id, r_t2_oob;

   logic              r_rsp0_valid, r_rsp1_valid;
   logic [DATA_W-1:0] r_rsp0_rdata, r_rsp1_rdata;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   // The counter idles at DEPTH for one cycle while the final sweep write
   // is on the RAM bus, so RUN begins the cycle after that write.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         INIT:    if (32'(r_init_cnt) == DEPTH) w_next_state = RUN;
         RUN:     w_next_state = RUN;
         default: w_next_state = INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_run        = 1'b0;
      w_issue_init = 1'b0;
      case (r_state)
         INIT:    w_issue_init = (32'(r_init_cnt) < DEPTH);
         RUN:     w_run        = 1'b1;
         default: ;
      endcase
   end

   assign init_done = w_run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init_cnt <= '0;
      end else if (w_issue_init) begin
         r_init_cnt <= r_init_cnt + 1'b1;
      end
   end

   // ---------------- arbitration ----------------
   rr_arb2 u_rr_arb2 (
      .i_valid (({req1_valid, req0_valid})),
      .i_last  (r_last),
      .o_grant (w_grant)
   );

   assign req0_ready = w_run & w_grant[0];
   assign req1_ready = w_run & w_grant[1];
   assign w_acc      = req0_ready | req1_ready;

   assign w_we    = req1_ready ? req1_we    : req0_we;
   assign w_addr  = req1_ready ? req1_addr  : req0_addr;
   assign w_wdata = req1_ready ? req1_wdata : req0_wdata;
   assign w_oob   = (32'(w_addr) >= DEPTH);

   // pointer resets to "last = 1" so req0 wins the first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_acc) begin
         r_last <= req1_ready;
      end
   end

   // ---------------- RAM command register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else if (w_issue_init) begin
         r_ram_en    <= 1'b1;
         r_ram_we    <= 1'b1;
         r_ram_addr  <= r_init_cnt[ADDR_W-1:0];
         r_ram_wdata <= '0;
      end else if (w_acc && !w_oob) begin
         r_ram_en    <= 1'b1;
         r_ram_we    <= w_we;
         r_ram_addr  <= w_addr;
         r_ram_wdata <= w_wdata;
      end else begin
         // out-of-range commands are accepted but never reach the RAM
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
      end
   end

   assign ram_en    = r_ram_en;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;

   // ---------------- read tag pipeline ----------------
   // Stage 1 lines up with the RAM command, stage 2 with ram_rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t1_vld <= 1'b0;
         r_t1_id  <= 1'b0;
         r_t1_oob <= 1'b0;
         r_t2_vld <= 1'b0;
         r_t2_id  <= 1'b0;
         r_t2_oob <= 1'b0;
      end else begin
         r_t1_vld <= w_acc & ~w_we;
         r_t1_id  <= req1_ready;
         r_t1_oob <= w_oob;
         r_t2_vld <= r_t1_vld;
         r_t2_id  <= r_t1_id;
         r_t2_oob <= r_t1_oob;
      end
   end

   // ---------------- responses ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
      end else begin
         r_rsp0_valid <= r_t2_vld & ~r_t2_id;
         r_rsp1_valid <= r_t2_vld &  r_t2_id;
         if (r_t2_vld && !r_t2_id) begin
            r_rsp0_rdata <= r_t2_oob ? '0 : ram_rdata;
         end
         if (r_t2_vld && r_t2_id) begin
            r_rsp1_rdata <= r_t2_oob ? '0 : ram_rdata;
         end
      end
   end

   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_rdata = r_rsp0_rdata;
   assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// A DEPTH=16 instance carries most of the stimulus; a DEPTH=12 instance
// covers out-of-range addressing. Both share clock and reset.
module tb_ram_arbiter;

   localparam int NCYC = 256;

   logic clk;
   logic rst_n;

   // DEPTH = 16 instance
   logic       a_v0, a_we0, a_v1, a_we1;
   logic [3:0] a_ad0, a_ad1;
   logic [7:0] a_wd0, a_wd1;
   logic       a_rdy0, a_rdy1, a_rv0, a_rv1;
   logic [7:0] a_rd0, a_rd1;
   logic       a_en, a_rwe, a_done;
   logic [3:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic [7:0] a_mem [0:15];

   // DEPTH = 12 instance
   logic       b_v0, b_we0, b_v1, b_we1;
   logic [3:0] b_ad0, b_ad1;
   logic [7:0] b_wd0, b_wd1;
   logic       b_rdy0, b_rdy1, b_rv0, b_rv1;
   logic [7:0] b_rd0, b_rd1;
   logic       b_en, b_rwe, b_done;
   logic [3:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic [7:0] b_mem [0:15];

   int n_checks;
   int n_fail;
   int cyc;

   // expected DUT16 responses per cycle
   logic       exp_v0 [0:NCYC-1];
   logic       exp_v1 [0:NCYC-1];
   logic [7:0] exp_d0 [0:NCYC-1];
   logic [7:0] exp_d1 [0:NCYC-1];

   ram_arbiter #(.DEPTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(a_v0), .req0_we(a_we0), .req0_addr(a_ad0), .req0_wdata(a_wd0), .req0_ready(a_rdy0),
      .req1_valid(a_v1), .req1_we(a_we1), .req1_addr(a_ad1), .req1_wdata(a_wd1), .req1_ready(a_rdy1),
      .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0), .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1),
      .ram_en(a_en), .ram_we(a_rwe), .ram_addr(a_addr), .ram_wdata(a_wdata),
      .ram_rdata(a_rdata), .init_done(a_done)
   );

   ram_arbiter #(.DEPTH(12)) dut12 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_v0), .req0_we(b_we0), .req0_addr(b_ad0), .req0_wdata(b_wd0), .req0_ready(b_rdy0),
      .req1_valid(b_v1), .req1_we(b_we1), .req1_addr(b_ad1), .req1_wdata(b_wd1), .req1_ready(b_rdy1),
      .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0), .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1),
      .ram_en(b_en), .ram_we(b_rwe), .ram_addr(b_addr), .ram_wdata(b_wdata),
      .ram_rdata(b_rdata), .init_done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port synchronous RAM models
   always @(posedge clk) begin
      if (a_en) begin
         if (a_rwe) a_mem[a_addr] <= a_wdata;
         else       a_rdata       <= a_mem[a_addr];
      end
      if (b_en) begin
         if (b_rwe) b_mem[b_addr] <= b_wdata;
         else       b_rdata       <= b_mem[b_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // advance one cycle, sample 1ns after the edge, check DUT16 responses
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < NCYC) begin
         check($sformatf("rsp0_valid@%0d", cyc), 32'(a_rv0), 32'(exp_v0[cyc]));
         check($sformatf("rsp1_valid@%0d", cyc), 32'(a_rv1), 32'(exp_v1[cyc]));
         if (exp_v0[cyc]) check($sformatf("rsp0_rdata@%0d", cyc), 32'(a_rd0), 32'(exp_d0[cyc]));
         if (exp_v1[cyc]) check($sformatf("rsp1_rdata@%0d", cyc), 32'(a_rd1), 32'(exp_d1[cyc]));
      end
   endtask

   task automatic expect_rsp(input int id, input logic [7:0] data);
      if (cyc + 3 < NCYC) begin
         if (id == 0) begin exp_v0[cyc+3] = 1'b1; exp_d0[cyc+3] = data; end
         else         begin exp_v1[cyc+3] = 1'b1; exp_d1[cyc+3] = data; end
      end
   endtask

   task automatic set_a0(input logic v, input logic we, input logic [3:0] ad, input logic [7:0] wd);
      a_v0 = v; a_we0 = we; a_ad0 = ad; a_wd0 = wd;
   endtask

   task automatic set_a1(input logic v, input logic we, input logic [3:0] ad, input logic [7:0] wd);
      a_v1 = v; a_we1 = we; a_ad1 = ad; a_wd1 = wd;
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'((i << 4) | (15 - i));
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      for (int i = 0; i < NCYC; i++) begin
         exp_v0[i] = 1'b0; exp_v1[i] = 1'b0; exp_d0[i] = '0; exp_d1[i] = '0;
      end
      rst_n = 1'b0;
      set_a0(0, 0, 0, 0); set_a1(0, 0, 0, 0);
      b_v0 = 0; b_we0 = 0; b_ad0 = 0; b_wd0 = 0;
      b_v1 = 0; b_we1 = 0; b_ad1 = 0; b_wd1 = 0;

      // ---- reset state ----
      tick(); tick();
      check("rst_ram_en",    32'(a_en),    0);
      check("rst_ram_we",    32'(a_rwe),   0);
      check("rst_ram_addr",  32'(a_addr),  0);
      check("rst_ram_wdata", 32'(a_wdata), 0);
      check("rst_init_done", 32'(a_done),  0);
      check("rst_rsp0_rdata",32'(a_rd0),   0);
      check("rst_rsp1_rdata",32'(a_rd1),   0);

      // ---- INIT sweep: requests held during INIT must not be accepted ----
      rst_n = 1'b1;
      set_a0(1, 0, 4'd1, 0); set_a1(1, 0, 4'd2, 0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("init_en_%0d", k),    32'(a_en),    1);
         check($sformatf("init_we_%0d", k),    32'(a_rwe),   1);
         check($sformatf("init_addr_%0d", k),  32'(a_addr),  32'(k - 1));
         check($sformatf("init_wdata_%0d", k), 32'(a_wdata), 0);
         check($sformatf("init_done_%0d", k),  32'(a_done),  0);
         check($sformatf("init_rdy0_%0d", k),  32'(a_rdy0),  0);
         check($sformatf("init_rdy1_%0d", k),  32'(a_rdy1),  0);
         if (k <= 12) check($sformatf("b_init_addr_%0d", k), 32'(b_addr), 32'(k - 1));
         if (k == 12) check("b_init_done_12", 32'(b_done), 0);
         if (k == 13) begin
            check("b_init_done_13", 32'(b_done), 1);
            check("b_init_en_13",   32'(b_en),   0);
         end
      end
      set_a0(0, 0, 0, 0); set_a1(0, 0, 0, 0);
      tick();
      check("init_done_17", 32'(a_done), 1);
      check("init_en_17",   32'(a_en),   0);

      // ---- req0 write 5=A5, req1 read 5 next cycle ----
      set_a0(1, 1, 4'd5, 8'hA5);
      #1;
      check("wr5_rdy0", 32'(a_rdy0), 1);
      check("wr5_rdy1", 32'(a_rdy1), 0);
      tick();
      check("wr5_ram_en",    32'(a_en),    1);
      check("wr5_ram_we",    32'(a_rwe),   1);
      check("wr5_ram_addr",  32'(a_addr),  5);
      check("wr5_ram_wdata", 32'(a_wdata), 32'h A5);
      set_a0(0, 0, 0, 0);
      set_a1(1, 0, 4'd5, 0);
      #1;
      check("rd5_rdy1", 32'(a_rdy1), 1);
      check("rd5_rdy0", 32'(a_rdy0), 0);
      expect_rsp(1, 8'hA5);
      tick();
      check("rd5_ram_en",   32'(a_en),   1);
      check("rd5_ram_we",   32'(a_rwe),  0);
      check("rd5_ram_addr", 32'(a_addr), 5);
      set_a1(0, 0, 0, 0);
      tick();
      check("idle_ram_en", 32'(a_en), 0);
      tick();

      // ---- req1 write 3=3C ----
      set_a1(1, 1, 4'd3, 8'h3C);
      #1;
      check("wr3_rdy1", 32'(a_rdy1), 1);
      tick();
      set_a1(0, 0, 0, 0);

      // ---- contention: grants alternate starting with req0 ----
      set_a0(1, 0, 4'd5, 0);
      set_a1(1, 0, 4'd3, 0);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_rdy0_%0d", i), 32'(a_rdy0), 32'((i % 2) == 0));
         check($sformatf("rr_rdy1_%0d", i), 32'(a_rdy1), 32'((i % 2) == 1));
         if ((i % 2) == 0) expect_rsp(0, 8'hA5);
         else              expect_rsp(1, 8'h3C);
         tick();
      end
      set_a0(0, 0, 0, 0); set_a1(0, 0, 0, 0);
      repeat (4) tick();

      // ---- req1 streams writes addr i = pat(i); no responses ----
      for (int i = 0; i < 16; i++) begin
         set_a1(1, 1, 4'(i), pat(i));
         #1;
         check($sformatf("wst_rdy1_%0d", i), 32'(a_rdy1), 1);
         tick();
         check($sformatf("wst_addr_%0d", i),  32'(a_addr),  32'(i));
         check($sformatf("wst_wdata_%0d", i), 32'(a_wdata), 32'(pat(i)));
      end
      set_a1(0, 0, 0, 0);

      // ---- req0 streams reads addr 0..15 ----
      for (int i = 0; i < 16; i++) begin
         set_a0(1, 0, 4'(i), 0);
         #1;
         check($sformatf("rst_rdy0_%0d", i), 32'(a_rdy0), 1);
         expect_rsp(0, pat(i));
         tick();
      end
      set_a0(0, 0, 0, 0);
      repeat (4) tick();
      check("rsp0_hold", 32'(a_rd0), 32'(pat(15)));

      // ---- reset one cycle after a read is accepted ----
      set_a0(1, 0, 4'd2, 0);
      #1;
      check("rr_read_rdy0", 32'(a_rdy0), 1);
      tick();
      set_a0(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_en",   32'(a_en),   0);
      check("mid_rst_done", 32'(a_done), 0);
      check("mid_rst_rsp0", 32'(a_rv0),  0);
      tick();
      rst_n = 1'b1;
      tick();
      check("resweep_en_0",   32'(a_en),   1);
      check("resweep_we_0",   32'(a_rwe),  1);
      check("resweep_addr_0", 32'(a_addr), 0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         check($sformatf("resweep_addr_%0d", k), 32'(a_addr), 32'(k));
      end
      tick();
      check("resweep_done", 32'(a_done), 1);

      // ---- DEPTH=12: out-of-range read returns zero ----
      b_v0 = 1; b_we0 = 1; b_ad0 = 4'd4; b_wd0 = 8'h77;
      #1;
      check("b_wr4_rdy0", 32'(b_rdy0), 1);
      tick();
      check("b_wr4_en",   32'(b_en),   1);
      check("b_wr4_addr", 32'(b_addr), 4);
      b_we0 = 0;
      #1;
      check("b_rd4_rdy0", 32'(b_rdy0), 1);
      tick();
      b_ad0 = 4'd13;
      #1;
      check("b_rd13_rdy0", 32'(b_rdy0), 1);
      t = cyc;
      tick();
      b_v0 = 0;
      check("b_rd13_ram_en", 32'(b_en), 0);
      tick();
      check("b_rd4_rsp_v", 32'(b_rv0), 1);
      check("b_rd4_rsp_d", 32'(b_rd0), 32'h77);
      tick();
      check("b_rd13_at_t3",  32'(cyc - t), 3);
      check("b_rd13_rsp_v",  32'(b_rv0), 1);
      check("b_rd13_rsp_d",  32'(b_rd0), 0);
      check("b_rd13_rsp1_v", 32'(b_rv1), 0);
      tick();
      check("b_rsp_drop",  32'(b_rv0), 0);
      check("b_rsp_hold",  32'(b_rd0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
